// File: rtl/pcie_phy_pkg.sv
// Shared PHY-side definitions: lane-mode encodings, active-lane clamping
// and the lane slicing helper used by the striping datapaths.
package pcie_phy_pkg;

  localparam logic [7:0] PAD_SYM_DEFAULT = 8'hF7;

  typedef enum logic [1:0] {
    MODE_X1 = 2'd0,
    MODE_X2 = 2'd1,
    MODE_X4 = 2'd2,
    MODE_X8 = 2'd3
  } mode_e;

  // count: lanes actually used; err: requested width exceeded the physical lanes
  typedef struct packed {
    logic [3:0] count;
    logic       err;
  } lane_cfg_t;

  // Clamp the requested width 2^mode to the number of physical lanes.
  function automatic lane_cfg_t active_lanes(input mode_e mode, input int lanes);
    lane_cfg_t cfg;
    int        req;
    req = 1 << mode;
    if (req > lanes) begin
      cfg.count = 4'(lanes);
      cfg.err   = 1'b1;
    end else begin
      cfg.count = 4'(req);
      cfg.err   = 1'b0;
    end
    return cfg;
  endfunction

  // LSB of lane k in a flat bus of w-bit lanes.
  function automatic int lane_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/stripe_out_reg.sv
// Output holding register for a lane group with valid/ready semantics.
// Data and lane enables stay frozen while valid is high and not consumed;
// a new group may be loaded in the same cycle the current one leaves.
module stripe_out_reg #(
  parameter int LANES  = 4,
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  input  logic [LANES*DATA_W-1:0] load_data,
  input  logic [LANES-1:0]        load_en,
  output logic                    load_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [LANES-1:0]        out_lane_en
);

  logic                    valid_q, valid_d;
  logic [LANES*DATA_W-1:0] data_q, data_d;
  logic [LANES-1:0]        en_q, en_d;

  // Register can take a group when empty or when its content leaves now.
  assign load_ready = !valid_q || out_ready;

  // Next-state: load has priority, otherwise drop valid on consumption.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    en_d    = en_q;
    if (load_valid && load_ready) begin
      valid_d = 1'b1;
      data_d  = load_data;
      en_d    = load_en;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      en_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      en_q    <= en_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_data    = data_q;
  assign out_lane_en = en_q;

endmodule

// File: rtl/byte_striping_tx_nlane.sv
// Byte-striping transmitter: spreads a byte stream round-robin over the
// active lanes, pads a short final group, and hands complete groups to a
// valid/ready output register. A completed group waits one cycle in the
// assembly register before moving out, so out_valid follows the completing
// byte by one edge.
module byte_striping_tx_nlane
  import pcie_phy_pkg::*;
#(
  parameter int                LANES   = 4,
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] PAD_SYM = DATA_W'(PAD_SYM_DEFAULT)
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [1:0]              MODE,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [LANES-1:0]        out_lane_en,
  output logic                    mode_err
);

  logic                         rst_done_q, rst_done_d;
  mode_e                        mode_q, mode_d;
  logic                         mode_err_q, mode_err_d;
  logic [3:0]                   idx_q, idx_d;
  logic [LANES-1:0][DATA_W-1:0] asm_q, asm_d;
  logic [LANES-1:0]             en_q, en_d;
  logic                         pend_q, pend_d;

  lane_cfg_t               cur_cfg;
  logic [3:0]              a_last;
  logic [LANES-1:0]        en_mask;
  logic [LANES*DATA_W-1:0] asm_flat;
  logic                    accept;
  logic                    complete;
  logic                    load_ready;
  logic                    xfer;

  assign cur_cfg = active_lanes(mode_q, LANES);
  assign a_last  = cur_cfg.count - 4'd1;

  // Per-lane active mask and flattening of the assembly register.
  genvar gi;
  for (gi = 0; gi < LANES; gi++) begin : g_lane
    assign en_mask[gi] = (4'(gi) < cur_cfg.count);
    assign asm_flat[lane_lsb(gi, DATA_W) +: DATA_W] = asm_q[gi];
  end

  // Input stalls only when a finished group is stuck behind a full output.
  assign in_ready = rst_done_q && !(pend_q && !load_ready);
  assign accept   = in_valid && in_ready;
  assign complete = accept && ((idx_q == a_last) || in_last);
  assign xfer     = pend_q && load_ready;

  // Assembly: write the byte to its slot, pad the tail on in_last, and
  // clear stale lanes when a new group starts (keeps unused lanes at 0).
  always_comb begin
    asm_d = asm_q;
    if (accept) begin
      for (int k = 0; k < LANES; k++) begin
        if (4'(k) == idx_q) begin
          asm_d[k] = in_data;
        end else if (in_last && (4'(k) > idx_q) && en_mask[k]) begin
          asm_d[k] = PAD_SYM;
        end else if (idx_q == 4'd0) begin
          asm_d[k] = '0;
        end
      end
    end
  end

  // Slot index, pending flag, lane-enable capture and mode latch.
  always_comb begin
    rst_done_d = 1'b1;
    idx_d      = idx_q;
    pend_d     = pend_q;
    en_d       = en_q;
    mode_d     = mode_q;
    mode_err_d = mode_err_q | cur_cfg.err;

    if (complete) begin
      idx_d = 4'd0;
    end else if (accept) begin
      idx_d = idx_q + 4'd1;
    end

    if (complete) begin
      pend_d = 1'b1;
      en_d   = en_mask;
    end else if (xfer) begin
      pend_d = 1'b0;
    end

    // Width only changes on a group boundary with no byte arriving.
    if ((idx_q == 4'd0) && !accept) begin
      mode_d = mode_e'(MODE);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      rst_done_q <= 1'b0;
      mode_q     <= MODE_X1;
      mode_err_q <= 1'b0;
      idx_q      <= 4'd0;
      asm_q      <= '0;
      en_q       <= '0;
      pend_q     <= 1'b0;
    end else begin
      rst_done_q <= rst_done_d;
      mode_q     <= mode_d;
      mode_err_q <= mode_err_d;
      idx_q      <= idx_d;
      asm_q      <= asm_d;
      en_q       <= en_d;
      pend_q     <= pend_d;
    end
  end

  assign mode_err = mode_err_q;

  stripe_out_reg #(
    .LANES  (LANES),
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk         (CLK),
    .rst_n       (RESET),
    .load_valid  (pend_q),
    .load_data   (asm_flat),
    .load_en     (en_q),
    .load_ready  (load_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_lane_en (out_lane_en)
  );

endmodule

// File: doc/byte_striping_tx_nlane.md
Name: byte_striping_tx_nlane

Overview:
Parametrised successor to the fixed 4-lane byte-striping transmitter. Takes a byte stream from the control/data mux and distributes it round-robin across LANES output lanes. The number of active lanes is runtime-selectable (x1/x2/x4/x8), and the block uses a valid/ready handshake on both sides. An incomplete final group is padded with PAD_SYM. It sits between the input mux and the per-lane parallel-to-serial converters; the byte-rate clock drives CLK.

Parameters:
LANES, 4, physical lane count; legal values 1, 2, 4, 8.
DATA_W, 8, bits per lane symbol.
PAD_SYM, 8'hF7, symbol used to fill unused active lanes after in_last; width DATA_W.

Ports:
CLK  input  1  byte-rate clock; all logic on rising edge.
RESET  input  1  synchronous, active-low reset.
MODE  input  2  requested active lanes: 0=x1, 1=x2, 2=x4, 3=x8.
in_valid  input  1  in_data/in_last valid this cycle.
in_data  input  DATA_W  byte to stripe.
in_last  input  1  marks final byte of a packet.
in_ready  output  1  block accepts a byte this cycle when in_valid && in_ready.
out_valid  output  1  out_data holds a complete lane group.
out_ready  input  1  downstream consumes the group when out_valid && out_ready.
out_data  output  LANES*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W].
out_lane_en  output  LANES  lane k carries data in this group (bit set for every active lane).
mode_err  output  1  sticky flag: MODE requested more lanes than LANES.

Behaviour:
- Reset (RESET==0 at a rising edge):
  - out_valid=0, out_data=0, out_lane_en=0, mode_err=0, in_ready=0.
  - Slot index=0, assembly and output registers empty, active mode latched to x1.
  - in_ready=1 from the first cycle after reset release.
- Mode latch:
  - MODE is sampled into mode_q only when the assembly register is empty (slot index 0) and no byte is accepted that cycle.
  - Changes mid-group are ignored until the group boundary.
  - Active lanes A = min(2^mode_q, LANES). If 2^MODE > LANES, A=LANES and mode_err is set; it stays set until reset.
- Assembly:
  - An accepted byte is written to slot idx (lane idx); then idx = idx+1.
  - First byte of a group always goes to lane 0.
- Group completion: happens when idx reaches A-1 on an accepted byte, or when an accepted byte has in_last=1.
  - On in_last with idx < A-1, lanes idx+1..A-1 are filled with PAD_SYM in the same cycle.
  - idx returns to 0.
  - Lanes >= A are driven 0 and their out_lane_en bits are 0.
- Output register:
  - A completed group moves to the output register at the next edge if the register is empty or is being consumed that same cycle (out_valid && out_ready).
  - Latency: byte completing a group at edge t gives out_valid=1 after edge t+1.
  - out_data and out_lane_en are held stable while out_valid && !out_ready.
- Backpressure:
  - If a completed group cannot move because the output register is full and not consumed, the group is held in assembly and in_ready=0.
  - in_ready is registered-free combinational: in_ready = !(group_pending && out_valid && !out_ready).
  - With out_ready held 1, throughput is one byte per cycle with no bubbles.
- Simultaneous events:
  - A group completing while the output register is consumed transfers with no bubble.
  - in_last on the A-th byte gives no padding.
- A=1 (x1): every accepted byte is a group; out_valid follows one cycle later.
- Reset mid-operation discards partial and pending groups. No partial group is emitted.

Decomposition:
- Shared package pcie_phy_pkg:
  - PAD_SYM default.
  - MODE encodings (MODE_X1..MODE_X8).
  - Function active_lanes(mode, LANES) returning the clamped count and the error bit.
  - Lane-slice helper for bits [k*DATA_W +: DATA_W].
- Sub-module stripe_out_reg: the output register with valid/ready hold semantics. The RX unstriping successor will reuse it.
- The assembly/index counter stays in the top module.

Test Plan:
- LANES=4, MODE=2, out_ready=1, bytes 01..08 back-to-back: two groups, out_data=04030201 then 08070605, out_lane_en=4'hF, each one cycle after its fourth byte, no bubbles.
- MODE=1 (x2), bytes AA,BB,CC with in_last on CC: groups 0000BBAA then 0000F7CC, out_lane_en=4'h3.
- out_ready=0 for 6 cycles during a continuous x4 stream: the first group is held stable, the second group assembles, and in_ready drops to 0 after the eighth byte. out_ready=1 releases both groups in order with no loss.
- MODE switched from 2 to 0 after the second byte of a group: the current group still completes as x4. The next group is x1: out_data=000000XX, out_lane_en=4'h1.
- LANES=4, MODE=3: mode_err=1 and sticky, behaviour matches x4. Pulsing RESET low mid-group clears mode_err, out_valid and the partial group, and in_ready=1 one cycle after release.
- x1 with in_last on every byte, bytes 10,11,12: three groups 00000010, 00000011, 00000012, with no PAD_SYM inserted.
